// File: rtl/rotate_pkg.sv
// Shared types and the reference rotate function for the pipelined rotator.
// rotate_by works on a MAX_WIDTH container so one function serves every WIDTH.
package rotate_pkg;

    typedef enum logic {
        ROTATE_RIGHT = 1'b0,
        ROTATE_LEFT  = 1'b1
    } rotate_direction_t;

    localparam int unsigned MAX_WIDTH = 64;
    localparam int unsigned IDX_W     = $clog2(MAX_WIDTH);

    // Only the low `width` bits of data/result are meaningful; the rest stay zero.
    function automatic logic [MAX_WIDTH-1:0] rotate_by(
        input logic [MAX_WIDTH-1:0] data,
        input int unsigned          amount,
        input rotate_direction_t    direction,
        input int unsigned          width
    );
        logic [MAX_WIDTH-1:0] result;
        int unsigned          a;
        result = '0;
        a      = amount % width;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                if (direction == ROTATE_RIGHT)
                    result[IDX_W'(i)] = data[IDX_W'((i + a) % width)];
                else
                    result[IDX_W'(i)] = data[IDX_W'((i + width - a) % width)];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rotate_pipelined_stage.sv
// One log-shifter stage: conditionally rotates by STEP using amount bit 0, then
// registers the result with the remaining amount bits behind a valid/ready slice.
module rotate_pipelined_stage
    import rotate_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned AMOUNT_W = 3,
    parameter int unsigned STEP     = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [AMOUNT_W-1:0] in_amount,
    input  rotate_direction_t   in_direction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic [AMOUNT_W-1:0] out_amount,
    output rotate_direction_t   out_direction
);

    logic                valid_q;
    logic [WIDTH-1:0]    data_q;
    logic [AMOUNT_W-1:0] amount_q;
    rotate_direction_t   direction_q;
    logic [WIDTH-1:0]    rotated;

    always_comb begin
        rotated = in_data;
        if (in_amount[0])
            rotated = WIDTH'(rotate_by(MAX_WIDTH'(in_data), STEP, in_direction, WIDTH));
    end

    // An empty slot always accepts, so bubbles collapse under a downstream stall.
    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            amount_q    <= '0;
            direction_q <= ROTATE_RIGHT;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q      <= rotated;
                amount_q    <= in_amount >> 1;
                direction_q <= in_direction;
            end
        end
    end

    assign out_valid     = valid_q;
    assign out_data      = data_q;
    assign out_amount    = amount_q;
    assign out_direction = direction_q;

endmodule

// File: rtl/rotate_pipelined.sv
// Dynamic pipelined rotator: AMOUNT_W stages, stage k rotating by 2^k mod WIDTH,
// chained through valid/ready so throughput is one transaction per cycle.
module rotate_pipelined
    import rotate_pkg::*;
#(
    parameter  int unsigned WIDTH    = 8,
    localparam int unsigned AMOUNT_W = $clog2(WIDTH)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    in_data,
    input  logic [AMOUNT_W-1:0] in_amount,
    input  logic                in_direction,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data
);

    logic [AMOUNT_W:0]   stage_valid;
    logic [AMOUNT_W:0]   stage_ready;
    logic [WIDTH-1:0]    stage_data      [AMOUNT_W+1];
    logic [AMOUNT_W-1:0] stage_amount    [AMOUNT_W+1];
    rotate_direction_t   stage_direction [AMOUNT_W+1];

    logic [AMOUNT_W-1:0] amount_unused;
    rotate_direction_t   direction_unused;

    assign stage_valid[0]     = in_valid;
    assign stage_data[0]      = in_data;
    assign stage_amount[0]    = in_amount;
    assign stage_direction[0] = rotate_direction_t'(in_direction);
    assign in_ready           = stage_ready[0];

    assign stage_ready[AMOUNT_W] = out_ready;
    assign out_valid             = stage_valid[AMOUNT_W];
    assign out_data              = stage_data[AMOUNT_W];

    // The amount is fully consumed by the last stage; its tail is intentionally dropped.
    assign amount_unused    = stage_amount[AMOUNT_W];
    assign direction_unused = stage_direction[AMOUNT_W];

    for (genvar k = 0; k < AMOUNT_W; k++) begin : g_stage
        rotate_pipelined_stage #(
            .WIDTH   (WIDTH),
            .AMOUNT_W(AMOUNT_W),
            .STEP    ((2 ** k) % WIDTH)
        ) u_stage (
            .clock        (clock),
            .reset        (reset),
            .in_valid     (stage_valid[k]),
            .in_ready     (stage_ready[k]),
            .in_data      (stage_data[k]),
            .in_amount    (stage_amount[k]),
            .in_direction (stage_direction[k]),
            .out_valid    (stage_valid[k+1]),
            .out_ready    (stage_ready[k+1]),
            .out_data     (stage_data[k+1]),
            .out_amount   (stage_amount[k+1]),
            .out_direction(stage_direction[k+1])
        );
    end

endmodule
